// File: rtl/tick_debouncer_if.sv
// Button debouncer signal bundle: tick/raw input from the driver side, clean level and
// event pulses back from the debouncer.
interface tick_debouncer_if;
  logic tick;
  logic btn_raw;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic long_press_pulse;

  modport master (
    output tick,
    output btn_raw,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  long_press_pulse
  );

  modport slave (
    input  tick,
    input  btn_raw,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output long_press_pulse
  );
endinterface

// File: rtl/tick_debouncer.sv
// Tick-sampled push-button debouncer with 2-FF synchronizer, registered clean level and
// one-cycle press, release and long-press pulses.
module tick_debouncer #(
  parameter int unsigned STABLE_TICKS     = 4,
  parameter int unsigned LONG_PRESS_TICKS = 100,
  parameter bit          ACTIVE_LOW       = 1'b1
) (
  input logic             clk_i,
  input logic             rst_i,
  tick_debouncer_if.slave btn_if
);

  localparam int unsigned CntW  = $clog2(STABLE_TICKS + 1);
  localparam int unsigned HoldW = $clog2(LONG_PRESS_TICKS + 1);

  localparam logic [CntW-1:0]  CntOne   = CntW'(1);
  localparam logic [CntW-1:0]  CntLast  = CntW'(STABLE_TICKS - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_PRESS_TICKS - 1);
  localparam logic [HoldW-1:0] HoldMax  = HoldW'(LONG_PRESS_TICKS);

  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StPressed,
    StReleaseWait
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             pressed;

  // Synchronizer resets to the released pin level so reset never looks like a press.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= ACTIVE_LOW;
      sync2_q <= ACTIVE_LOW;
    end else begin
      sync1_q <= btn_if.btn_raw;
      sync2_q <= sync1_q;
    end
  end

  assign pressed = sync2_q ^ ACTIVE_LOW;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    if (btn_if.tick) begin
      unique case (state_q)
        StIdle: begin
          if (pressed) begin
            state_d = StPressWait;
            cnt_d   = CntOne;
          end
        end
        StPressWait: begin
          if (!pressed) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (cnt_q == CntLast) begin
            state_d = StPressed;
            cnt_d   = '0;
            hold_d  = '0;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        StPressed: begin
          if (pressed) begin
            // Saturating hold makes the long-press event fire at most once per press.
            if (hold_q != HoldMax) hold_d = hold_q + HoldW'(1);
            if (hold_q == HoldLast) long_d = 1'b1;
          end else begin
            state_d = StReleaseWait;
            cnt_d   = CntOne;
          end
        end
        StReleaseWait: begin
          if (pressed) begin
            state_d = StPressed;
            cnt_d   = '0;
          end else if (cnt_q == CntLast) begin
            state_d   = StIdle;
            cnt_d     = '0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    level_d = (state_d == StPressed) || (state_d == StReleaseWait);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hold_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  assign btn_if.btn_level        = level_q;
  assign btn_if.press_pulse      = press_q;
  assign btn_if.release_pulse    = release_q;
  assign btn_if.long_press_pulse = long_q;

endmodule
